// File: rtl/cpu_wb_merge.sv
// cpu_wb_merge: writeback merge unit for the CPU pipeline.
// Tagged results from NUM_CH fire-and-forget return channels are queued in
// per-channel FIFOs. A round-robin arbiter drains the FIFOs into the single
// late-writeback slot of the complete stage.
// Optional build macro CPU_WB_BYPASS_EN: when every FIFO is empty and the
// complete stage is ready, a same-cycle push can go straight to the output
// register. This gives one cycle of latency instead of two.
module cpu_wb_merge #(
   parameter int NUM_CH   = 3,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 2,
   parameter int TAG_W    = 9
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       ch_valid,
   input  logic [32*NUM_CH-1:0]    ch_data,
   input  logic [TAG_W*NUM_CH-1:0] ch_tag,
   output logic [NUM_CH-1:0]       ch_almost_full,
   input  logic                    cpu_ready,
   output logic [4:0]              read_dest_reg,
   output logic [31:0]             read_data,
   output logic [NUM_CH-1:0]       overflow
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int RW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int EW    = 37;
   localparam int AF_TH = (DEPTH > AF_LEVEL) ? (DEPTH - AF_LEVEL) : 0;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_TH);

   // FIFO storage: entry = {dest[4:0], data[31:0]}; not reset, pointers qualify it
   logic [EW-1:0]     mem_q    [NUM_CH][DEPTH];
   logic [PW-1:0]     wr_ptr_q [NUM_CH];
   logic [PW-1:0]     rd_ptr_q [NUM_CH];
   logic [CW-1:0]     cnt_q    [NUM_CH];
   logic [CW-1:0]     cnt_d    [NUM_CH];
   logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] af_q, af_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [4:0]        dest_q, dest_d;
   logic [31:0]       data_q, data_d;

   logic [4:0]        push_dest [NUM_CH];
   logic [31:0]       push_data [NUM_CH];
   logic [NUM_CH-1:0] push_ok, empty, full, req, pop, enq, wr_en;
   logic              bypass;
   logic              found;
   logic              grant;
   logic [RW-1:0]     winner;
   logic [EW-1:0]     head;

   // Decode channel pushes; a zero destination means "no writeback" and is dropped
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         push_dest[i] = ch_tag[TAG_W*i +: 5];
         push_data[i] = ch_data[32*i +: 32];
         push_ok[i]   = ch_valid[i] && (push_dest[i] != 5'd0);
         empty[i]     = (cnt_q[i] == '0);
         full[i]      = (cnt_q[i] == FULL_CNT);
      end
   end

`ifdef CPU_WB_BYPASS_EN
   // Idle queues let live pushes compete directly for the output slot
   assign bypass = cpu_ready && (&empty);
`else
   assign bypass = 1'b0;
`endif

   assign req   = bypass ? push_ok : ~empty;
   assign grant = cpu_ready && found;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i] && (((int'(rr_ptr_q) + k) % NUM_CH) == i)) begin
               found  = 1'b1;
               winner = RW'(i);
            end
         end
      end
   end

   // Select the entry presented by the winner (FIFO head, or live push on bypass)
   always_comb begin
      head = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(winner) == i) begin
            head = bypass ? {push_dest[i], push_data[i]} : mem_q[i][rd_ptr_q[i]];
         end
      end
   end

   // Per-channel push/pop resolution, overflow and occupancy next state
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i]   = grant && !bypass && (int'(winner) == i);
         // a bypassed winner is consumed directly and never enqueued
         enq[i]   = push_ok[i] && !(grant && bypass && (int'(winner) == i));
         // a full FIFO still accepts a push when its head leaves the same cycle
         wr_en[i] = enq[i] && (!full[i] || pop[i]);
         if (enq[i] && full[i] && !pop[i]) begin
            ovf_d[i] = 1'b1;
         end
         cnt_d[i] = cnt_q[i] + CW'(wr_en[i]) - CW'(pop[i]);
         af_d[i]  = (cnt_d[i] >= AF_CNT);
      end
   end

   // Arbiter pointer and output slot next state
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      dest_d   = 5'd0;
      data_d   = data_q;
      if (grant) begin
         if (int'(winner) == NUM_CH - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = winner + RW'(1);
         end
         dest_d = head[36:32];
         data_d = head[31:0];
      end
   end

   // Control state: pointers, counts, arbiter, flags and the output register
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         rr_ptr_q <= '0;
         af_q     <= '0;
         ovf_q    <= '0;
         dest_q   <= 5'd0;
         data_q   <= 32'd0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
            cnt_q[i] <= cnt_d[i];
         end
         rr_ptr_q <= rr_ptr_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
         dest_q   <= dest_d;
         data_q   <= data_d;
      end
   end

   // FIFO storage writes
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en[i]) begin
            mem_q[i][wr_ptr_q[i]] <= {push_dest[i], push_data[i]};
         end
      end
   end

   assign ch_almost_full = af_q;
   assign overflow       = ovf_q;
   assign read_dest_reg  = dest_q;
   assign read_data      = data_q;

endmodule

// File: tb/tb_cpu_wb_merge.sv
// Directed bench for cpu_wb_merge (default parameters: 3 channels, depth 4).
module tb_cpu_wb_merge;

`ifdef CPU_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clock;
   logic        reset;
   logic [2:0]  ch_valid;
   logic [95:0] ch_data;
   logic [26:0] ch_tag;
   logic [2:0]  ch_almost_full;
   logic        cpu_ready;
   logic [4:0]  read_dest_reg;
   logic [31:0] read_data;
   logic [2:0]  overflow;

   int n_chk;
   int n_fail;

   cpu_wb_merge #(
      .NUM_CH  (3),
      .DEPTH   (4),
      .AF_LEVEL(2),
      .TAG_W   (9)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ch_valid      (ch_valid),
      .ch_data       (ch_data),
      .ch_tag        (ch_tag),
      .ch_almost_full(ch_almost_full),
      .cpu_ready     (cpu_ready),
      .read_dest_reg (read_dest_reg),
      .read_data     (read_data),
      .overflow      (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  v;
      logic [4:0]  t0, t1, t2;
      logic [31:0] d0, d1, d2;
      logic        rdy;
      logic [4:0]  e_dest;
      logic [31:0] e_data;
      logic [2:0]  e_af;
      logic [2:0]  e_ovf;
   } vec_t;

   vec_t tbl [24];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
   // Tag upper bits are set to a nonzero pattern; only [4:0] matters.
   task automatic step(input logic [2:0] v, input logic [4:0] t0, input logic [4:0] t1,
                       input logic [4:0] t2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic rdy);
      ch_valid  = v;
      ch_tag    = {4'hA, t2, 4'hA, t1, 4'hA, t0};
      ch_data   = {d2, d1, d0};
      cpu_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic rdy);
      step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, rdy);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(1'b0);
      idle(1'b0);
      reset = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic [4:0] ed, input logic [31:0] edata);
      chk({name, "_dest"}, 64'(read_dest_reg), 64'(ed));
      chk({name, "_data"}, 64'(read_data), 64'(edata));
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b1;
      ch_valid  = '0;
      ch_tag    = '0;
      ch_data   = '0;
      cpu_ready = 1'b0;

      // Vector table: fill ch0 past full, drain; full ch1 with push+pop; zero-dest pushes
      tbl[0]  = '{3'b001, 5'd1,  5'd0,  5'd0, 32'h100, 32'h0,  32'h0, 1'b0, 5'd0,  32'h0,   3'b000, 3'b000};
      tbl[1]  = '{3'b001, 5'd2,  5'd0,  5'd0, 32'h200, 32'h0,  32'h0, 1'b0, 5'd0,  32'h0,   3'b001, 3'b000};
      tbl[2]  = '{3'b001, 5'd3,  5'd0,  5'd0, 32'h300, 32'h0,  32'h0, 1'b0, 5'd0,  32'h0,   3'b001, 3'b000};
      tbl[3]  = '{3'b001, 5'd4,  5'd0,  5'd0, 32'h400, 32'h0,  32'h0, 1'b0, 5'd0,  32'h0,   3'b001, 3'b000};
      tbl[4]  = '{3'b001, 5'd5,  5'd0,  5'd0, 32'h500, 32'h0,  32'h0, 1'b0, 5'd0,  32'h0,   3'b001, 3'b001};
      tbl[5]  = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd1,  32'h100, 3'b001, 3'b001};
      tbl[6]  = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd2,  32'h200, 3'b001, 3'b001};
      tbl[7]  = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd3,  32'h300, 3'b000, 3'b001};
      tbl[8]  = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd4,  32'h400, 3'b000, 3'b001};
      tbl[9]  = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd0,  32'h400, 3'b000, 3'b001};
      tbl[10] = '{3'b010, 5'd0,  5'd10, 5'd0, 32'h0,   32'hA0, 32'h0, 1'b0, 5'd0,  32'h400, 3'b000, 3'b001};
      tbl[11] = '{3'b010, 5'd0,  5'd11, 5'd0, 32'h0,   32'hB0, 32'h0, 1'b0, 5'd0,  32'h400, 3'b010, 3'b001};
      tbl[12] = '{3'b010, 5'd0,  5'd12, 5'd0, 32'h0,   32'hC0, 32'h0, 1'b0, 5'd0,  32'h400, 3'b010, 3'b001};
      tbl[13] = '{3'b010, 5'd0,  5'd13, 5'd0, 32'h0,   32'hD0, 32'h0, 1'b0, 5'd0,  32'h400, 3'b010, 3'b001};
      tbl[14] = '{3'b010, 5'd0,  5'd14, 5'd0, 32'h0,   32'hE0, 32'h0, 1'b1, 5'd10, 32'hA0,  3'b010, 3'b001};
      tbl[15] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd11, 32'hB0,  3'b010, 3'b001};
      tbl[16] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd12, 32'hC0,  3'b010, 3'b001};
      tbl[17] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd13, 32'hD0,  3'b000, 3'b001};
      tbl[18] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd14, 32'hE0,  3'b000, 3'b001};
      tbl[19] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd0,  32'hE0,  3'b000, 3'b001};
      tbl[20] = '{3'b111, 5'd0,  5'd0,  5'd0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b0, 5'd0, 32'hE0, 3'b000, 3'b001};
      tbl[21] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd0,  32'hE0,  3'b000, 3'b001};
      tbl[22] = '{3'b111, 5'd0,  5'd0,  5'd0, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1, 5'd0, 32'hE0, 3'b000, 3'b001};
      tbl[23] = '{3'b000, 5'd0,  5'd0,  5'd0, 32'h0,   32'h0,  32'h0, 1'b1, 5'd0,  32'hE0,  3'b000, 3'b001};

      // Reset state
      do_reset();
      chk_out("reset", 5'd0, 32'd0);
      chk("reset_af", 64'(ch_almost_full), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);

      // Single push on channel 1, then the slot must clear again
      for (int s = 0; s < 3; s++) begin
         if (s == 0) step(3'b010, 5'd0, 5'd7, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 1'b1);
         else        idle(1'b1);
         chk_out($sformatf("single_s%0d", s), (s == LAT - 1) ? 5'd7 : 5'd0,
                 (s >= LAT - 1) ? 32'hDEADBEEF : 32'd0);
      end

      // All three channels in one cycle: drained 3,4,5 on consecutive cycles
      do_reset();
      for (int s = 0; s < 5; s++) begin
         int j;
         logic [4:0]  ed;
         logic [31:0] edata;
         j = s - (LAT - 1);
         if (s == 0) step(3'b111, 5'd3, 5'd4, 5'd5, 32'h33, 32'h44, 32'h55, 1'b1);
         else        idle(1'b1);
         ed    = (j >= 0 && j < 3) ? 5'(3 + j) : 5'd0;
         edata = (j < 0) ? 32'd0 : (j < 3) ? 32'(32'h33 + 32'h11 * j) : 32'h55;
         chk_out($sformatf("rr3_s%0d", s), ed, edata);
      end
      // Pointer back at 0: channel 0 wins over channel 2
      step(3'b101, 5'd8, 5'd0, 5'd9, 32'h88, 32'd0, 32'h99, 1'b0);
      chk_out("rrwrap_s0", 5'd0, 32'h55);
      idle(1'b1);
      chk_out("rrwrap_s1", 5'd8, 32'h88);
      idle(1'b1);
      chk_out("rrwrap_s2", 5'd9, 32'h99);
      idle(1'b1);
      chk_out("rrwrap_s3", 5'd0, 32'h99);

      // Table-driven vectors
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step(tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
         chk_out($sformatf("row%0d", i), tbl[i].e_dest, tbl[i].e_data);
         chk($sformatf("row%0d_af", i), 64'(ch_almost_full), 64'(tbl[i].e_af));
         chk($sformatf("row%0d_ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
      end

      // Reset with entries queued and an output in flight
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(3'b010, 5'd0, 5'(20 + k), 5'd0, 32'd0, 32'(32'h2000 + k), 32'd0, 1'b0);
      end
      chk("pre_ovf", 64'(overflow), 64'b010);
      idle(1'b1);
      chk_out("pre_out", 5'd20, 32'h2000);
      reset = 1'b1;
      idle(1'b1);
      reset = 1'b0;
      chk_out("midrst", 5'd0, 32'd0);
      chk("midrst_ovf", 64'(overflow), 64'd0);
      chk("midrst_af", 64'(ch_almost_full), 64'd0);
      idle(1'b1);
      chk_out("midrst_empty", 5'd0, 32'd0);
      step(3'b101, 5'd6, 5'd0, 5'd7, 32'h66, 32'd0, 32'h77, 1'b0);
      idle(1'b1);
      chk_out("midrst_rr0", 5'd6, 32'h66);
      idle(1'b1);
      chk_out("midrst_rr1", 5'd7, 32'h77);
      idle(1'b1);
      chk_out("midrst_rr2", 5'd0, 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_wb_merge.md
Name: cpu_wb_merge

Overview:
- Parametrised writeback merge unit for the CPU pipeline.
- Collects tagged results from NUM_CH fire-and-forget return channels (e.g. dcache, address decoder, divider) into per-channel FIFOs.
- Round-robin arbitrates the FIFOs into the single late-writeback slot presented to the complete stage.
- Generalises the fixed three-source read FIFO: arbitrary channel count, configurable depth, almost-full backpressure hints and overflow detection.

Parameters:
- NUM_CH, 3, number of return channels (1..8).
- DEPTH, 4, entries per channel FIFO; power of two, >=2.
- AF_LEVEL, 2, per-channel almost-full asserted when occupancy >= DEPTH-AF_LEVEL.
- TAG_W, 9, width of return tag; bits [4:0] are the destination register.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ch_valid  input  NUM_CH  per-channel result strobe; cannot be stalled.
- ch_data  input  32*NUM_CH  channel i data at [32*i+31:32*i].
- ch_tag  input  TAG_W*NUM_CH  channel i tag at [TAG_W*i+TAG_W-1:TAG_W*i].
- ch_almost_full  output  NUM_CH  registered occupancy hint to issue logic.
- cpu_ready  input  1  complete stage has a free writeback slot this cycle.
- read_dest_reg  output  5  writeback register; 0 = no writeback.
- read_data  output  32  writeback data, qualified by read_dest_reg != 0.
- overflow  output  NUM_CH  sticky per-channel overflow flags.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - All FIFOs empty.
  - rr_ptr=0.
  - read_dest_reg=0, read_data=0.
  - ch_almost_full=0, overflow=0.
- Reset mid-operation discards all queued entries and drops any in-flight output.
- Push rules:
  - A push with ch_valid[i]=1 and tag[4:0]==0 is discarded. It is not enqueued and not counted.
  - Otherwise the push writes {tag[4:0], data} at the write pointer.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Full FIFO:
  - Push without a same-cycle pop: entry dropped, overflow[i] set. It stays set until reset.
  - Push with a same-cycle pop: both take effect, count unchanged.
- Arbitration, each cycle with cpu_ready=1:
  - Search channels from rr_ptr upward, modulo NUM_CH.
  - The first non-empty FIFO is granted and popped.
  - On a grant, rr_ptr <= winner+1 (mod NUM_CH). rr_ptr is unchanged when there is no grant.
- Output register:
  - On a grant, read_dest_reg/read_data <= head entry.
  - With no grant, or cpu_ready=0, read_dest_reg <= 0 and read_data holds its value.
  - Each entry is presented for exactly one cycle, never repeated.
- Latency: a push in cycle N becomes visible in the FIFO in N+1. The earliest output is registered at the end of N+1, so read_dest_reg is valid in cycle N+2.
- cpu_ready=0: no pops; pushes continue.
- ch_almost_full[i] is registered from the next-cycle count, so it reflects occupancy after this cycle's push and pop.
- Ordering: within a channel, strict FIFO order. Across channels, no ordering guarantee.

Optional Feature:
- Macro: CPU_WB_BYPASS_EN.
- Defined:
  - Applies when cpu_ready=1 and every FIFO is empty (start of cycle).
  - Valid pushes take part in the round-robin search in that same cycle; the winner is written directly to the output register, giving latency 1 (valid in N+1).
  - The winner is not enqueued. Losing pushes are enqueued normally.
  - rr_ptr updates as for a normal grant.
- Undefined: all pushes are enqueued; latency is as above.
- The overflow, almost-full and ordering rules are identical in both builds.

Test Plan:
- Reset, then ch_valid[1]=1, tag=0x007, data=0xDEADBEEF, cpu_ready=1 → read_dest_reg=7, read_data=0xDEADBEEF two cycles later (one with CPU_WB_BYPASS_EN), then read_dest_reg=0.
- Same cycle, all three channels push dests 3/4/5 with cpu_ready=1 and rr_ptr=0 → outputs dest 3, 4, 5 on consecutive cycles; rr_ptr ends at 0.
- cpu_ready=0; channel 0 pushes 4 entries (DEPTH=4), then a 5th → ch_almost_full[0]=1 after the 2nd push, overflow[0]=1 after the 5th. Raising cpu_ready then drains exactly the first 4 entries in order.
- Full FIFO with simultaneous push and pop → overflow stays 0, count stays 4, pushed entry emerges 4th.
- Push with tag[4:0]=0 → nothing enqueued, read_dest_reg stays 0.
- Assert reset while 3 entries are queued → next cycle all FIFOs empty, read_dest_reg=0, overflow=0, rr_ptr=0.
